key_debounce: RTL and testbench

//  Input-side counterpart to the board LED drivers: it reads the 4 active-low pushbuttons.
//  It synchronises and debounces each button on a shared slow sample tick.
//  It emits a level plus one-cycle press, release and long-press events for each key.

---
 rtl/key_pkg.sv | 16 +
 rtl/key_debounce_ch.sv | 118 +++++++++++
 rtl/key_debounce.sv | 57 +++++
 tb/tb_key_debounce.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton debouncer: per-key FSM state codes
// and default timing constants for a 50 MHz system clock.
package key_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t DB_DOWN = 2'd1;
  localparam state_t HELD    = 2'd2;
  localparam state_t DB_UP   = 2'd3;

  // 1 ms sample tick at 50 MHz, and 20 samples to accept a level change.
  localparam int KEY_TICK_DIV_1MS = 50_000;
  localparam int KEY_DEB_20MS     = 20;

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: two-flop synchroniser, debounce FSM advanced on the
// shared sample tick, and registered level / press / release / long outputs.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEB_TICKS  = KEY_DEB_20MS,
  parameter int LONG_TICKS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic tick,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CNT_W  = $clog2(DEB_TICKS);
  localparam int HOLD_W = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'((LONG_TICKS > 0) ? LONG_TICKS - 1 : 0);

  logic              sync1;
  logic              sync2;
  logic              lvl;
  state_t            st;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold;

  // Bring the asynchronous pin into the clock domain; reset reads as released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign lvl = ~sync2;

  // Debounce FSM; pulses default low every cycle so each lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= IDLE;
      cnt         <= '0;
      hold        <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      if (tick) begin
        case (st)
          IDLE: begin
            if (lvl) begin
              st  <= DB_DOWN;
              cnt <= CNT_ONE;
            end
          end
          DB_DOWN: begin
            if (!lvl) begin
              st  <= IDLE;
              cnt <= '0;
            end else if (cnt == CNT_LAST) begin
              st        <= HELD;
              cnt       <= '0;
              hold      <= '0;
              key_press <= 1'b1;
              key_state <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          HELD: begin
            if (!lvl) begin
              st  <= DB_UP;
              cnt <= CNT_ONE;
            end else if (hold != HOLD_MAX) begin
              // Saturating hold count; the long pulse fires on reaching the limit.
              hold <= hold + HOLD_ONE;
              if (hold == HOLD_PRE) key_long <= 1'b1;
            end
          end
          DB_UP: begin
            if (lvl) begin
              // Bounce back to pressed keeps hold, so key_long cannot fire twice.
              st  <= HELD;
              cnt <= '0;
            end else if (cnt == CNT_LAST) begin
              st          <= IDLE;
              cnt         <= '0;
              hold        <= '0;
              key_release <= 1'b1;
              key_state   <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            st  <= IDLE;
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Pushbutton front end: one shared sample-tick divider feeding an
// independent debounce channel per active-low key.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS   = 4,
  parameter int TICK_DIV   = KEY_TICK_DIV_1MS,
  parameter int DEB_TICKS  = KEY_DEB_20MS,
  parameter int LONG_TICKS = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int TDIV_W = $clog2(TICK_DIV);

  localparam logic [TDIV_W-1:0] TDIV_ONE  = TDIV_W'(1);
  localparam logic [TDIV_W-1:0] TDIV_LAST = TDIV_W'(TICK_DIV - 1);

  logic [TDIV_W-1:0] tcnt;
  logic              tick;

  assign tick = (tcnt == TDIV_LAST);

  // Free-running divider 0..TICK_DIV-1; tick marks its last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TDIV_ONE;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEB_TICKS  (DEB_TICKS),
      .LONG_TICKS (LONG_TICKS)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_n       (key_n[g]),
      .tick        (tick),
      .key_state   (key_state[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g]),
      .key_long    (key_long[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios followed by random
// key activity, all compared cycle by cycle against a run-length debounce model.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int LT = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS   (NK),
    .TICK_DIV   (TD),
    .DEB_TICKS  (DB),
    .LONG_TICKS (LT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: accepted level, length of the current run of samples that
  // disagree with it, and number of pressed samples counted while held.
  bit            acc  [NK];
  int            run  [NK];
  int            hold [NK];
  logic [NK-1:0] hist [$];
  int            k;
  int            cyc = 0;
  logic [NK-1:0] exp_state, exp_press, exp_release, exp_long;

  int            press_cnt [NK];
  int            rel_cnt   [NK];
  int            long_cnt  [NK];
  int            press_edge[NK];
  int            rel_edge  [NK];
  int            long_edge [NK];
  int            press_k   [NK];
  bit            seen_press_1001;
  bit            seen_rel_1001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    k = 0;
    hist.delete();
    for (int i = 0; i < NK; i++) begin
      acc[i]  = 1'b0;
      run[i]  = 0;
      hold[i] = 0;
    end
    exp_state   = '0;
    exp_press   = '0;
    exp_release = '0;
    exp_long    = '0;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < NK; i++) begin
      press_cnt[i]  = 0;
      rel_cnt[i]    = 0;
      long_cnt[i]   = 0;
      press_edge[i] = -1;
      rel_edge[i]   = -1;
      long_edge[i]  = -1;
      press_k[i]    = -1;
    end
    seen_press_1001 = 1'b0;
    seen_rel_1001   = 1'b0;
  endtask

  // One clock edge: advance the model, then compare all outputs just after it.
  task automatic step();
    logic [NK-1:0] lvl;
    @(posedge clk);
    k++;
    cyc++;
    hist.push_back(~key_n);
    if (hist.size() > 3) void'(hist.pop_front());
    // The value seen by the debouncer is the pin as captured two edges earlier.
    lvl = (hist.size() == 3) ? hist[0] : '0;
    exp_press   = '0;
    exp_release = '0;
    exp_long    = '0;
    if (k % TD == 0) begin
      for (int i = 0; i < NK; i++) begin
        if (lvl[i] != acc[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            acc[i] = lvl[i];
            run[i] = 0;
            if (lvl[i]) begin
              exp_press[i] = 1'b1;
              hold[i]      = 0;
            end else begin
              exp_release[i] = 1'b1;
            end
          end
        end else begin
          if (acc[i] && run[i] == 0 && hold[i] < LT) begin
            hold[i]++;
            if (hold[i] == LT) exp_long[i] = 1'b1;
          end
          run[i] = 0;
        end
        exp_state[i] = acc[i];
      end
    end
    #1;
    chk("state",   key_state,   exp_state);
    chk("press",   key_press,   exp_press);
    chk("release", key_release, exp_release);
    chk("long",    key_long,    exp_long);
    for (int i = 0; i < NK; i++) begin
      if (key_press[i])   begin press_cnt[i]++; press_edge[i] = cyc; press_k[i] = k; end
      if (key_release[i]) begin rel_cnt[i]++;   rel_edge[i]   = cyc; end
      if (key_long[i])    begin long_cnt[i]++;  long_edge[i]  = cyc; end
    end
    if (key_press == 4'b1001)   seen_press_1001 = 1'b1;
    if (key_release == 4'b1001) seen_rel_1001   = 1'b1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int c0;
    rst   = 1'b1;
    key_n = 4'b1111;
    model_reset();
    clr_counts();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reset asserted mid-count with all keys released.
    steps(6);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_state",   key_state,   4'b0000);
    chk("rst_press",   key_press,   4'b0000);
    chk("rst_release", key_release, 4'b0000);
    chk("rst_long",    key_long,    4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single press on key 0, held 40 cycles.
    clr_counts();
    steps(1);
    c0 = cyc;
    key_n = 4'b1110;
    steps(40);
    chk("s2_press_cnt", press_cnt[0], 1);
    chk("s2_press_lat", (press_edge[0] - c0) <= 15, 1);
    chk("s2_state",     key_state, 4'b0001);
    chk("s2_others",    press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    key_n = 4'b1111;
    steps(30);
    chk("s2_rel_cnt", rel_cnt[0], 1);

    // Bouncing key 1 never holds long enough to be accepted.
    clr_counts();
    while (k % TD != 3) step();
    for (int r = 0; r < 5; r++) begin
      key_n = 4'b1101;
      steps(6);
      key_n = 4'b1111;
      steps(2);
    end
    steps(20);
    chk("s3_press_cnt", press_cnt[1], 0);
    chk("s3_rel_cnt",   rel_cnt[1],   0);
    chk("s3_state",     key_state[1], 1'b0);

    // Long press on key 2.
    clr_counts();
    key_n = 4'b1011;
    steps(80);
    chk("s4_press_cnt", press_cnt[2], 1);
    chk("s4_long_cnt",  long_cnt[2],  1);
    chk("s4_long_gap",  long_edge[2] - press_edge[2], 40);
    c0 = cyc;
    key_n = 4'b1111;
    steps(20);
    chk("s4_rel_cnt", rel_cnt[2], 1);
    chk("s4_rel_lat", (rel_edge[2] - c0) <= 15, 1);

    // Keys 0 and 3 pressed and released together.
    clr_counts();
    key_n = 4'b0110;
    steps(30);
    chk("s5_press_1001", seen_press_1001, 1'b1);
    key_n = 4'b1111;
    steps(30);
    chk("s5_rel_1001",   seen_rel_1001, 1'b1);
    chk("s5_long_none",  long_cnt[0] + long_cnt[3], 0);

    // Reset while key 0 is held: no release, then a fresh press.
    clr_counts();
    key_n = 4'b1110;
    steps(30);
    chk("s6_held", key_state[0], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s6_rst_state", key_state,   4'b0000);
    chk("s6_rst_rel",   key_release, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    steps(30);
    chk("s6_no_release", rel_cnt[0], 0);
    chk("s6_press_k",    press_k[0], 12);
    key_n = 4'b1111;
    steps(30);

    // Random key activity with one reset in the middle.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(0, 23) == 0) key_n[i] = ~key_n[i];
      end
      if (c == 400) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rnd_rst_state", key_state, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
